traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//  Demand-actuated phase scheduler for a 4-approach junction. Latches vehicle/pedestrian
//  requests, grants one green phase at a time (round-robin), sequences green->yellow->all-red,
//  rests in main-road green (phase 0) when idle, and supports emergency preemption to phase 0.
//  Drives per-phase 3-bit lamp codes (001 green, 010 yellow, 100 red) for the lamp driver level.
// PARAMETERS
//  TG0   7  min green cycles, phase 0 (main through; rest phase)
//  TG1   5  green cycles, phase 1 (main turn)
//  TG2   3  green cycles, phase 2 (side road)
//  TG3   4  green cycles, phase 3 (pedestrian walk)
//  TY    2  yellow cycles
//  TR    1  all-red clearance cycles
//  CW    4  timer width; every T* must satisfy 1 <= T* <= 2**CW-1
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset (0 = reset asserted)
//  req        in   4   request per phase, level or pulse, sampled each clk
//  emerg      in   1   emergency preempt, level
//  light      out  12  lamp codes, phase i at [3i+2:3i]
//  grant      out  4   one-hot green phase, 0 when not in GREEN
//  phase      out  2   current/last granted phase
//  st         out  2   state: 0 GREEN, 1 YELLOW, 2 ALL_RED
//  emerg_ack  out  1   1 when st==GREEN, phase==0, emerg==1
// BEHAVIOUR
//  Reset (async, rst==0): st=ALL_RED, timer=0, phase=3, pend=0; light=12'h924 (all 100),
//   grant=0, emerg_ack=0. Outputs decode combinationally from registered state/phase/timer.
//  Timer counts 0..N-1 in each state; a state with duration N lasts exactly N cycles.
//  pend[i] sets when req[i]==1, except while phase i is in GREEN (ignored). pend[i] clears
//   on the edge that enters GREEN for phase i; that clear beats a same-cycle set.
//  GREEN, phase p != 0: after TG[p] cycles -> YELLOW. emerg==1 -> YELLOW on next edge
//   regardless of timer.
//  GREEN, phase 0: timer saturates at TG0-1. Leaves for YELLOW only when timer==TG0-1,
//   any pend[3:1]==1, and emerg==0. Otherwise holds green indefinitely (rest).
//  YELLOW: TY cycles, then ALL_RED. Not cut short by emerg.
//  ALL_RED: TR cycles, then GREEN for next phase:
//   emerg==1 -> 0; else first pend[k]==1 scanning k=phase+1, phase+2, ... mod 4, over 1..3
//   only (phase 0 is never a scan target); none pending -> 0.
//  Lamp decode: granted phase 001 in GREEN, 010 in YELLOW; all other phases always 100.
//   In ALL_RED all are 100.
//  Never more than one phase non-red. grant==0 outside GREEN.
//  Phase 0 re-entered from itself (no pend, emerg) is legal; it still passes YELLOW/ALL_RED
//   only if it left GREEN.
//  Reset asserted mid-sequence: immediate all-red; restarts with TR all-red, then phase 0.
// TESTING
//  Release rst, no req -> 1 cycle all-red (12'h924), then grant=0001; holds 20+ cycles.
//  After rest, pulse req[2] 1 cycle -> phase0 green until timer reaches TG0-1, then YELLOW.
//   Continue: 2 Y, 1 R, grant=0100 for 3, 2 Y, 1 R, grant=0001.
//  req[1] and req[3] both pulsed during phase-0 green -> serve 1 (5 cyc), then 3 (4 cyc),
//   then 0; pend==0 at end.
//  emerg=1 on cycle 1 of phase-2 green -> YELLOW next edge, 2 Y, 1 R, phase 0 green,
//   emerg_ack=1. pend[3] set meanwhile is held until emerg drops, then served.
//  req[2] held high through its own green -> not re-latched; after return to 0, pend[2]==0.
//  rst pulsed low mid-YELLOW (async, between edges) -> light=12'h924 immediately;
//   pend cleared; restart per first test.
//  Assert in every cycle: popcount(grant)<=1, at most one non-100 lamp field.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Demand-actuated phase scheduler for a 4-approach junction. Requests are
//   latched per phase, and only one phase is green at a time. Each phase runs
//   the sequence green -> yellow -> all-red. The next phase is picked
//   round-robin from the pending requests. When idle, the scheduler rests in
//   phase 0 (main through) green. Emergency preemption steers the sequence to
//   phase 0.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous reset, active low
//   req[3:0]   per-phase request (level or pulse), sampled every clk
//   emerg      emergency preempt (level)
//   light[11:0] lamp code of phase i at [3i+2:3i]: 001 green, 010 yellow, 100 red
//   grant[3:0] one-hot green phase, zero outside GREEN
//   phase[1:0] current / last granted phase
//   st[1:0]    0 GREEN, 1 YELLOW, 2 ALL_RED
//   emerg_ack  high while phase 0 is green and emerg is asserted
module traffic_phase_scheduler #(
  parameter int unsigned TG0 = 7,
  parameter int unsigned TG1 = 5,
  parameter int unsigned TG2 = 3,
  parameter int unsigned TG3 = 4,
  parameter int unsigned TY  = 2,
  parameter int unsigned TR  = 1,
  parameter int unsigned CW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic        emerg,
  output logic [11:0] light,
  output logic [3:0]  grant,
  output logic [1:0]  phase,
  output logic [1:0]  st,
  output logic        emerg_ack
);

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2
  } state_t;

  localparam logic [CW-1:0] TG0_LAST = CW'(TG0 - 1);
  localparam logic [CW-1:0] TG1_LAST = CW'(TG1 - 1);
  localparam logic [CW-1:0] TG2_LAST = CW'(TG2 - 1);
  localparam logic [CW-1:0] TG3_LAST = CW'(TG3 - 1);
  localparam logic [CW-1:0] TY_LAST  = CW'(TY - 1);
  localparam logic [CW-1:0] TR_LAST  = CW'(TR - 1);

  state_t        state;
  logic [CW-1:0] timer;
  logic [1:0]    ph;
  logic [3:0]    pend;

  logic [3:0]    ph_onehot;
  logic [3:0]    green_mask;
  logic [CW-1:0] green_last;
  logic [1:0]    nxt_ph;
  logic [1:0]    cand;
  logic          found;
  logic          red_done;
  logic [3:0]    pend_d;

  assign ph_onehot  = 4'b0001 << ph;
  assign green_mask = (state == GREEN) ? ph_onehot : '0;
  assign red_done   = (state == ALL_RED) && (timer == TR_LAST);

  always_comb begin
    case (ph)
      2'd0:    green_last = TG0_LAST;
      2'd1:    green_last = TG1_LAST;
      2'd2:    green_last = TG2_LAST;
      default: green_last = TG3_LAST;
    endcase
  end

  // Round-robin scan starting after the current phase. Step 4 wraps back to
  // the current phase itself. Phase 0 is never a scan target; it is the
  // fallback when nothing is pending.
  always_comb begin
    nxt_ph = 2'd0;
    found  = 1'b0;
    cand   = 2'd0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ph + 2'(i);
      if (!found && (cand != 2'd0) && pend[cand]) begin
        nxt_ph = cand;
        found  = 1'b1;
      end
    end
    if (emerg) begin
      nxt_ph = 2'd0;
    end
  end

  // A request for the phase that is currently green is ignored. Entering
  // GREEN clears that phase's request, even against a same-cycle set.
  always_comb begin
    pend_d = pend | (req & ~green_mask);
    if (red_done) begin
      pend_d[nxt_ph] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ALL_RED;
      timer <= '0;
      ph    <= 2'd3;
      pend  <= '0;
    end else begin
      pend <= pend_d;
      case (state)
        GREEN: begin
          if (ph != 2'd0) begin
            if (emerg || (timer == green_last)) begin
              state <= YELLOW;
              timer <= '0;
            end else begin
              timer <= timer + CW'(1);
            end
          end else if (timer == TG0_LAST) begin
            // Rest phase: the timer saturates, and the phase waits here
            // for a side demand while no emergency is active.
            if ((|pend[3:1]) && !emerg) begin
              state <= YELLOW;
              timer <= '0;
            end
          end else begin
            timer <= timer + CW'(1);
          end
        end
        YELLOW: begin
          if (timer == TY_LAST) begin
            state <= ALL_RED;
            timer <= '0;
          end else begin
            timer <= timer + CW'(1);
          end
        end
        ALL_RED: begin
          if (red_done) begin
            state <= GREEN;
            timer <= '0;
            ph    <= nxt_ph;
          end else begin
            timer <= timer + CW'(1);
          end
        end
        default: begin
          state <= ALL_RED;
          timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    light = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      light[3*i +: 3] = 3'b100;
      if (ph == 2'(i)) begin
        if (state == GREEN) begin
          light[3*i +: 3] = 3'b001;
        end else if (state == YELLOW) begin
          light[3*i +: 3] = 3'b010;
        end
      end
    end
  end

  assign grant     = green_mask;
  assign phase     = ph;
  assign st        = state;
  assign emerg_ack = (state == GREEN) && (ph == 2'd0) && emerg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  typedef struct {
    int         n;
    logic [3:0]  req;
    logic        emerg;
    logic [11:0] light;
    logic [3:0]  grant;
    logic [1:0]  st;
    logic [1:0]  ph;
    logic        ack;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic        emerg;
  logic [11:0] light;
  logic [3:0]  grant;
  logic [1:0]  phase;
  logic [1:0]  st;
  logic        emerg_ack;

  int tests;
  int fails;

  vec_t tbl[$];

  traffic_phase_scheduler #(
    .TG0(7), .TG1(5), .TG2(3), .TG3(4), .TY(2), .TR(1), .CW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .emerg(emerg),
    .light(light),
    .grant(grant),
    .phase(phase),
    .st(st),
    .emerg_ack(emerg_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input int n, input logic [3:0] r, input logic e,
                             input logic [11:0] l, input logic [3:0] g,
                             input logic [1:0] s, input logic [1:0] p,
                             input logic a);
    vec_t x;
    x.n = n; x.req = r; x.emerg = e; x.light = l;
    x.grant = g; x.st = s; x.ph = p; x.ack = a;
    return x;
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, check outputs mid-cycle, then move
  // on to the next falling edge (one rising edge in between).
  task automatic step(input vec_t x, input string tag);
    for (int k = 0; k < x.n; k++) begin
      req   = x.req;
      emerg = x.emerg;
      #1;
      chk($sformatf("%s.%0d light", tag, k), light, x.light);
      chk($sformatf("%s.%0d grant", tag, k), {8'h0, grant}, {8'h0, x.grant});
      chk($sformatf("%s.%0d st", tag, k), {10'h0, st}, {10'h0, x.st});
      chk($sformatf("%s.%0d phase", tag, k), {10'h0, phase}, {10'h0, x.ph});
      chk($sformatf("%s.%0d ack", tag, k), {11'h0, emerg_ack}, {11'h0, x.ack});
      @(negedge clk);
    end
  endtask

  // Per-cycle safety: at most one granted phase and at most one non-red lamp.
  always @(posedge clk) begin
    int nonred;
    #2;
    nonred = 0;
    for (int i = 0; i < 4; i++) begin
      if (light[3*i +: 3] != 3'b100) nonred++;
    end
    tests++;
    if ($countones(grant) > 1) begin
      fails++;
      $display("FAIL inv_grant: got %b required at most one bit set", grant);
    end
    tests++;
    if (nonred > 1) begin
      fails++;
      $display("FAIL inv_lamps: got %h (%0d non-red) required at most 1", light, nonred);
    end
  end

  initial begin
    rst   = 1'b0;
    req   = '0;
    emerg = 1'b0;

    // Power-up rest: one all-red cycle, then phase 0 holds green.
    tbl.push_back(v( 1, 4'h0, 0, 12'h924, 4'h0, 2, 3, 0));
    tbl.push_back(v(20, 4'h0, 0, 12'h921, 4'h1, 0, 0, 0));
    // Single pulse on phase 2 while phase 0 rests.
    tbl.push_back(v( 1, 4'h4, 0, 12'h921, 4'h1, 0, 0, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h921, 4'h1, 0, 0, 0));
    tbl.push_back(v( 2, 4'h0, 0, 12'h922, 4'h0, 1, 0, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h924, 4'h0, 2, 0, 0));
    tbl.push_back(v( 3, 4'h0, 0, 12'h864, 4'h4, 0, 2, 0));
    tbl.push_back(v( 2, 4'h0, 0, 12'h8a4, 4'h0, 1, 2, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h924, 4'h0, 2, 2, 0));
    // Phases 1 and 3 requested on the first cycle of phase-0 green: min green 7.
    tbl.push_back(v( 1, 4'ha, 0, 12'h921, 4'h1, 0, 0, 0));
    tbl.push_back(v( 6, 4'h0, 0, 12'h921, 4'h1, 0, 0, 0));
    tbl.push_back(v( 2, 4'h0, 0, 12'h922, 4'h0, 1, 0, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h924, 4'h0, 2, 0, 0));
    tbl.push_back(v( 5, 4'h0, 0, 12'h90c, 4'h2, 0, 1, 0));
    tbl.push_back(v( 2, 4'h0, 0, 12'h914, 4'h0, 1, 1, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h924, 4'h0, 2, 1, 0));
    tbl.push_back(v( 4, 4'h0, 0, 12'h324, 4'h8, 0, 3, 0));
    tbl.push_back(v( 2, 4'h0, 0, 12'h524, 4'h0, 1, 3, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h924, 4'h0, 2, 3, 0));
    tbl.push_back(v(12, 4'h0, 0, 12'h921, 4'h1, 0, 0, 0));
    // req[2] held through its own green: the clear on entry wins, and it is not re-latched.
    tbl.push_back(v( 2, 4'h4, 0, 12'h921, 4'h1, 0, 0, 0));
    tbl.push_back(v( 2, 4'h4, 0, 12'h922, 4'h0, 1, 0, 0));
    tbl.push_back(v( 1, 4'h4, 0, 12'h924, 4'h0, 2, 0, 0));
    tbl.push_back(v( 3, 4'h4, 0, 12'h864, 4'h4, 0, 2, 0));
    tbl.push_back(v( 2, 4'h0, 0, 12'h8a4, 4'h0, 1, 2, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h924, 4'h0, 2, 2, 0));
    tbl.push_back(v(10, 4'h0, 0, 12'h921, 4'h1, 0, 0, 0));
    // Emergency on cycle 1 of phase-2 green; pend[3] latched during yellow.
    tbl.push_back(v( 1, 4'h4, 0, 12'h921, 4'h1, 0, 0, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h921, 4'h1, 0, 0, 0));
    tbl.push_back(v( 2, 4'h0, 0, 12'h922, 4'h0, 1, 0, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h924, 4'h0, 2, 0, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h864, 4'h4, 0, 2, 0));
    tbl.push_back(v( 1, 4'h0, 1, 12'h864, 4'h4, 0, 2, 0));
    tbl.push_back(v( 1, 4'h8, 1, 12'h8a4, 4'h0, 1, 2, 0));
    tbl.push_back(v( 1, 4'h0, 1, 12'h8a4, 4'h0, 1, 2, 0));
    tbl.push_back(v( 1, 4'h0, 1, 12'h924, 4'h0, 2, 2, 0));
    tbl.push_back(v(10, 4'h0, 1, 12'h921, 4'h1, 0, 0, 1));
    tbl.push_back(v( 1, 4'h0, 0, 12'h921, 4'h1, 0, 0, 0));
    tbl.push_back(v( 2, 4'h0, 0, 12'h922, 4'h0, 1, 0, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h924, 4'h0, 2, 0, 0));
    tbl.push_back(v( 4, 4'h0, 0, 12'h324, 4'h8, 0, 3, 0));
    tbl.push_back(v( 2, 4'h0, 0, 12'h524, 4'h0, 1, 3, 0));
    tbl.push_back(v( 1, 4'h0, 0, 12'h924, 4'h0, 2, 3, 0));
    tbl.push_back(v( 3, 4'h0, 0, 12'h921, 4'h1, 0, 0, 0));

    @(negedge clk);
    #1;
    chk("reset light", light, 12'h924);
    chk("reset grant", {8'h0, grant}, 12'h000);
    chk("reset st", {10'h0, st}, 12'h002);
    chk("reset phase", {10'h0, phase}, 12'h003);
    chk("reset ack", {11'h0, emerg_ack}, 12'h000);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("v%0d", i));
    end

    // Reset asserted mid-yellow, between clock edges.
    step(v(1, 4'ha, 0, 12'h921, 4'h1, 0, 0, 0), "pre_rst_req");
    step(v(3, 4'h0, 0, 12'h921, 4'h1, 0, 0, 0), "pre_rst_green");
    step(v(1, 4'h0, 0, 12'h922, 4'h0, 1, 0, 0), "pre_rst_yellow");
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst light", light, 12'h924);
    chk("async_rst grant", {8'h0, grant}, 12'h000);
    chk("async_rst st", {10'h0, st}, 12'h002);
    chk("async_rst phase", {10'h0, phase}, 12'h003);
    @(negedge clk);
    rst = 1'b1;
    step(v( 1, 4'h0, 0, 12'h924, 4'h0, 2, 3, 0), "post_rst_red");
    step(v(12, 4'h0, 0, 12'h921, 4'h1, 0, 0, 0), "post_rst_rest");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
